// File: rtl/buzz_pkg.sv
// Shared types and helpers for the keypad buzzer arbiter.
//   src_e   : requester codes, numerically ordered by priority (lock highest)
//   state_e : pattern sequencer phases
//   pick_winner / takes_over : same-cycle arbitration and preemption rules
package buzz_pkg;

  localparam int DUR_W  = 27;  // holds PASS_CYC-1 at 50 MHz
  localparam int HALF_W = 16;
  localparam int BEEP_W = 4;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_CLICK = 3'd1,
    SRC_PASS  = 3'd2,
    SRC_FAIL  = 3'd3,
    SRC_LOCK  = 3'd4
  } src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Highest-priority request of this cycle; the rest are discarded.
  function automatic src_e pick_winner(input logic click, input logic pass,
                                       input logic fail, input logic lock);
    if (lock)  return SRC_LOCK;
    if (fail)  return SRC_FAIL;
    if (pass)  return SRC_PASS;
    if (click) return SRC_CLICK;
    return SRC_NONE;
  endfunction

  // A higher request preempts, an equal one restarts. Lock is a level, so
  // while it is already being served it must not restart every cycle.
  function automatic logic takes_over(input src_e req, input src_e cur);
    if (req == SRC_NONE) return 1'b0;
    if (req > cur)       return 1'b1;
    return (req == cur) && (req != SRC_LOCK);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator for the buzzer.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : phase is TONE in the coming cycle
//   restart    : a TONE phase begins in the coming cycle (tone restarts high)
//   half       : half-period in cycles
//   tone       : tone level for the coming cycle (next-state value), so the
//                caller's output register lines up with its own state registers
module tone_gen
  import buzz_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              restart,
  input  logic [HALF_W-1:0] half,
  output logic              tone
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              ph_q;
  logic              wrap;

  always_comb begin
    wrap  = (cnt_q == half - HALF_W'(1));
    tone  = 1'b0;
    cnt_d = '0;
    if (restart) begin
      tone  = 1'b1;
      cnt_d = '0;
    end else if (en) begin
      tone  = wrap ? ~ph_q : ph_q;
      cnt_d = wrap ? '0 : cnt_q + HALF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= tone;
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter and pattern sequencer for the keypad password lock.
//   clk, rst_n  : 50 MHz clock, synchronous active-low reset
//   req_click   : pulse, digit accepted        (short low tone)
//   req_pass    : pulse, password correct      (long high-pitch tone)
//   req_fail    : pulse, password wrong        (ALARM_BEEPS bursts)
//   req_lock    : level, try limit reached     (bursts while high)
//   mute        : silences the pin; sequencing continues
//   buzzer      : registered square-wave drive
//   busy        : a pattern is active
//   active_src  : source being served (src_e code)
// Requests are sampled on the edge that also loads the new state, so all
// outputs reflect a request right after the sampling edge.
module buzzer_arbiter
  import buzz_pkg::*;
#(
  parameter int unsigned TONE_HALF   = 50000,
  parameter int unsigned PASS_HALF   = 25000,
  parameter int unsigned CLICK_CYC   = 10000000,
  parameter int unsigned PASS_CYC    = 50000000,
  parameter int unsigned ALARM_ON    = 12500000,
  parameter int unsigned ALARM_OFF   = 12500000,
  parameter int unsigned ALARM_BEEPS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_click,
  input  logic       req_pass,
  input  logic       req_fail,
  input  logic       req_lock,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] active_src
);

  localparam logic [HALF_W-1:0] TONE_H     = HALF_W'(TONE_HALF);
  localparam logic [HALF_W-1:0] PASS_H     = HALF_W'(PASS_HALF);
  localparam logic [DUR_W-1:0]  CLICK_LAST = DUR_W'(CLICK_CYC - 1);
  localparam logic [DUR_W-1:0]  PASS_LAST  = DUR_W'(PASS_CYC - 1);
  localparam logic [DUR_W-1:0]  ON_LAST    = DUR_W'(ALARM_ON - 1);
  localparam logic [DUR_W-1:0]  OFF_LAST   = DUR_W'(ALARM_OFF - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST  = BEEP_W'(ALARM_BEEPS - 1);

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [BEEP_W-1:0]  beep_q, beep_d;
  logic               busy_q, buzzer_q;

  src_e               win;
  logic [DUR_W-1:0]   tone_last;
  logic               restart;
  logic               tone;
  logic [HALF_W-1:0]  half;

  always_comb begin
    case (src_q)
      SRC_CLICK: tone_last = CLICK_LAST;
      SRC_PASS:  tone_last = PASS_LAST;
      default:   tone_last = ON_LAST;
    endcase
  end

  always_comb begin
    win     = pick_winner(req_click, req_pass, req_fail, req_lock);
    state_d = state_q;
    src_d   = src_q;
    dur_d   = dur_q;
    beep_d  = beep_q;
    restart = 1'b0;

    if (takes_over(win, src_q)) begin
      state_d = TONE;
      src_d   = win;
      dur_d   = '0;
      beep_d  = '0;
      restart = 1'b1;
    end else if (src_q == SRC_LOCK && !req_lock) begin
      // lock released: stop immediately, even mid-burst
      state_d = IDLE;
      src_d   = SRC_NONE;
      dur_d   = '0;
      beep_d  = '0;
    end else begin
      case (state_q)
        TONE: begin
          if (dur_q == tone_last) begin
            dur_d = '0;
            if (src_q == SRC_FAIL || src_q == SRC_LOCK) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
              src_d   = SRC_NONE;
            end
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        GAP: begin
          if (dur_q == OFF_LAST) begin
            dur_d = '0;
            // lock reaching here means req_lock is still high
            if (src_q == SRC_LOCK || beep_q != BEEP_LAST) begin
              state_d = TONE;
              restart = 1'b1;
              if (src_q == SRC_FAIL) beep_d = beep_q + BEEP_W'(1);
            end else begin
              state_d = IDLE;
              src_d   = SRC_NONE;
              beep_d  = '0;
            end
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        default: ;
      endcase
    end

    half = (src_d == SRC_PASS) ? PASS_H : TONE_H;
  end

  tone_gen u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_d == TONE),
    .restart (restart),
    .half    (half),
    .tone    (tone)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= SRC_NONE;
      dur_q    <= '0;
      beep_q   <= '0;
      busy_q   <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dur_q    <= dur_d;
      beep_q   <= beep_d;
      busy_q   <= (state_d != IDLE);
      buzzer_q <= tone & ~mute;
    end
  end

  assign buzzer     = buzzer_q;
  assign busy       = busy_q;
  assign active_src = src_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench for buzzer_arbiter: the driver computes the expected
// outputs from elapsed time within each pattern and queues them; the
// monitor compares them against the DUT one cycle at a time.
module tb_buzzer_arbiter;

  localparam int TH = 4, PH = 2, CK = 20, PC = 16, ON = 8, OFF = 6, BE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, req_click = 1'b0, req_pass = 1'b0;
  logic       req_fail = 1'b0, req_lock = 1'b0, mute = 1'b0;
  logic       buzzer, busy;
  logic [2:0] active_src;

  always #5 clk = ~clk;

  buzzer_arbiter #(
    .TONE_HALF(TH), .PASS_HALF(PH), .CLICK_CYC(CK), .PASS_CYC(PC),
    .ALARM_ON(ON), .ALARM_OFF(OFF), .ALARM_BEEPS(BE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_click(req_click), .req_pass(req_pass),
    .req_fail(req_fail), .req_lock(req_lock), .mute(mute),
    .buzzer(buzzer), .busy(busy), .active_src(active_src)
  );

  typedef struct {
    logic       buz;
    logic       bsy;
    logic [2:0] src;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, passed = 0, cyc = 0;
  int   m_src = 0, m_t = 0;

  function automatic int pat_len(input int s);
    case (s)
      1:       return CK;
      2:       return PC;
      3:       return BE * (ON + OFF);
      default: return 0;
    endcase
  endfunction

  // Tone level t cycles into a pattern of source s.
  function automatic bit exp_tone(input int s, input int t);
    int w;
    case (s)
      1: return ((t / TH) % 2) == 0;
      2: return ((t / PH) % 2) == 0;
      3, 4: begin
        w = t % (ON + OFF);
        return (w < ON) && (((w / TH) % 2) == 0);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit r, input bit c, input bit p, input bit f,
                      input bit l, input bit m);
    int   win;
    exp_t e;
    @(negedge clk);
    rst_n = r; req_click = c; req_pass = p; req_fail = f; req_lock = l; mute = m;
    cyc++;
    win = l ? 4 : f ? 3 : p ? 2 : c ? 1 : 0;
    if (!r) begin
      m_src = 0; m_t = 0;
    end else if (win != 0 && (win > m_src || (win == m_src && win != 4))) begin
      m_src = win; m_t = 0;
    end else if (m_src == 4 && !l) begin
      m_src = 0; m_t = 0;
    end else if (m_src != 0) begin
      m_t++;
      if (m_src != 4 && m_t >= pat_len(m_src)) begin
        m_src = 0; m_t = 0;
      end
    end
    e.buz = (m_src != 0) && exp_tone(m_src, m_t) && !m;
    e.bsy = (m_src != 0);
    e.src = 3'(m_src);
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit l, input bit m);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, l, m);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (buzzer === e.buz && busy === e.bsy && active_src === e.src)
        passed++;
      else
        $display("FAIL outputs cyc %0d: buzzer/busy/src got %b/%b/%0d want %b/%b/%0d",
                 e.cyc, buzzer, busy, active_src, e.buz, e.bsy, e.src);
    end
  end

  initial begin
    bit lk, mt;
    // reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // single click
    idle(5, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(30, 0, 0);
    // fail pattern including the last gap
    step(1, 0, 0, 1, 0, 0);
    idle(45, 0, 0);
    // click preempted by fail; click during fail ignored
    step(1, 1, 0, 0, 0, 0);
    idle(6, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    idle(10, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(40, 0, 0);
    // lock held for 50 cycles
    idle(50, 1, 0);
    idle(10, 0, 0);
    // pass under mute
    step(1, 0, 1, 0, 0, 0);
    idle(2, 0, 0);
    idle(20, 0, 1);
    // reset during second fail burst, then a clean click
    step(1, 0, 0, 1, 0, 0);
    idle(16, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(3, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(25, 0, 0);
    // equal-priority restart
    step(1, 1, 0, 0, 0, 0);
    idle(10, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(25, 0, 0);
    // random traffic
    lk = 0; mt = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 79) == 0) lk = ~lk;
      if ($urandom_range(0, 29) == 0) mt = ~mt;
      step($urandom_range(0, 499) != 0,
           $urandom_range(0, 14) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0,
           lk, mt);
    end
    idle(3, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
